wrr_pop_scheduler: RTL

Weighted round-robin scheduler that drains four virtual-channel FIFOs into the shared round-robin output mux. Each cycle it decides which FIFO is popped and drives the mux channel select (`arbiter`) and per-channel valid flags. Each channel gets up to a programmable number of consecutive pops (its weight) per turn. It sits between the VC FIFOs and the round-robin mux, and honours downstream back-pressure.

---
 rtl/wrr_pop_scheduler_pkg.sv | 19 +
 rtl/wrr_pop_scheduler_rr_next_finder.sv | 25 ++
 rtl/wrr_pop_scheduler.sv | 124 ++++++++++++
 3 files changed

// File: rtl/wrr_pop_scheduler_pkg.sv
// Shared constants and state encoding for the weighted round-robin pop scheduler.
package wrr_pop_scheduler_pkg;

  localparam int NUM_CH = 4;
  localparam int WGHT_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  localparam logic [NUM_CH-1:0] EMPTY = 4'b0000;

  localparam logic [1:0] VCHANEL0 = 2'd0;
  localparam logic [1:0] VCHANEL1 = 2'd1;
  localparam logic [1:0] VCHANEL2 = 2'd2;
  localparam logic [1:0] VCHANEL3 = 2'd3;

endpackage

// File: rtl/wrr_pop_scheduler_rr_next_finder.sv
// Rotating-priority search: first eligible channel at or after base, wrapping 3->0.
module rr_next_finder
  import wrr_pop_scheduler_pkg::*;
(
  input  logic [NUM_CH-1:0] eligible,
  input  logic [1:0]        base,
  output logic              found,
  output logic [1:0]        idx
);

  // NOTE: every output gets a default before the loop so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    found = 1'b0;
    idx   = base;
    // Walk from the farthest offset down so the nearest eligible channel wins.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (eligible[base + 2'(i)]) begin
        found = 1'b1;
        idx   = base + 2'(i);
      end
    end
  end

endmodule

// File: rtl/wrr_pop_scheduler.sv
// Weighted round-robin scheduler draining four VC FIFOs into the shared output mux.
module wrr_pop_scheduler
  import wrr_pop_scheduler_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              enb,
  input  logic [NUM_CH-1:0] fifo_empty,
  input  logic              dest_full,
  input  logic [WGHT_W-1:0] weight0,
  input  logic [WGHT_W-1:0] weight1,
  input  logic [WGHT_W-1:0] weight2,
  input  logic [WGHT_W-1:0] weight3,
  output logic [NUM_CH-1:0] pop,
  output logic [1:0]        arbiter,
  output logic [NUM_CH-1:0] valid_channel,
  output logic              busy
);

  state_t            state, state_n;
  logic [1:0]        cur, cur_n, ptr, ptr_n, cur_inc;
  logic [WGHT_W-1:0] credit, credit_n;
  logic [WGHT_W-1:0] weight [NUM_CH];
  logic [NUM_CH-1:0] eligible;
  logic              run, turn_end;
  logic              idle_found, next_found;
  logic [1:0]        idle_idx, next_idx;

  assign weight[VCHANEL0] = weight0;
  assign weight[VCHANEL1] = weight1;
  assign weight[VCHANEL2] = weight2;
  assign weight[VCHANEL3] = weight3;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      eligible[i] = ~fifo_empty[i] & (weight[i] != '0);
    end
  end

  assign cur_inc = cur + 2'd1;
  assign run     = rst & enb & ~dest_full;
  assign busy    = (state == SERVE);

  rr_next_finder u_idle_find (
    .eligible (eligible),
    .base     (ptr),
    .found    (idle_found),
    .idx      (idle_idx)
  );

  rr_next_finder u_next_find (
    .eligible (eligible),
    .base     (cur_inc),
    .found    (next_found),
    .idx      (next_idx)
  );

  always_comb begin
    state_n  = state;
    cur_n    = cur;
    ptr_n    = ptr;
    credit_n = credit;
    pop      = EMPTY;
    turn_end = 1'b0;
    if (run) begin
      case (state)
        IDLE: begin
          if (idle_found) begin
            state_n  = SERVE;
            cur_n    = idle_idx;
            credit_n = weight[idle_idx];
          end
        end
        SERVE: begin
          // An empty FIFO ends the turn without a pop; leftover credit is dropped.
          if (fifo_empty[cur]) begin
            turn_end = 1'b1;
          end else begin
            pop[cur] = 1'b1;
            credit_n = credit - WGHT_W'(1);
            turn_end = (credit == WGHT_W'(1));
          end
          if (turn_end) begin
            if (next_found) begin
              cur_n    = next_idx;
              credit_n = weight[next_idx];
            end else begin
              state_n  = IDLE;
              ptr_n    = cur_inc;
              credit_n = '0;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      cur           <= VCHANEL0;
      ptr           <= VCHANEL0;
      credit        <= '0;
      arbiter       <= VCHANEL0;
      valid_channel <= EMPTY;
    end else if (enb) begin
      state  <= state_n;
      cur    <= cur_n;
      ptr    <= ptr_n;
      credit <= credit_n;
      // Select/valid trail the pop by one cycle to line up with FIFO read data.
      if (dest_full) begin
        valid_channel <= EMPTY;
      end else begin
        arbiter       <= cur;
        valid_channel <= pop;
      end
    end
  end

endmodule
